// File: rtl/pong_score_ctrl_pkg.sv
// Shared types and constants for the pong score controller.
// Holds the FSM state encoding, winner codes, the blank display nibble and
// the binary-to-BCD helper used to build the scoreboard value.
package pong_score_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SERVE_WAIT = 3'd1,
    ST_PLAY       = 3'd2,
    ST_POINT      = 3'd3,
    ST_GAME_OVER  = 3'd4
  } state_t;

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_P1    = 2'b01;
  localparam logic [1:0] WIN_P2    = 2'b10;
  localparam logic [3:0] BCD_BLANK = 4'hF;
  localparam int         BALL_X_W  = 12;

  // 0..99 -> {tens, ones}; repeated subtraction keeps it divider-free.
  function automatic logic [7:0] bin2bcd(input logic [6:0] v);
    logic [6:0] rem;
    logic [3:0] tens;
    rem  = v;
    tens = 4'd0;
    for (int i = 0; i < 9; i++) begin
      if (rem >= 7'd10) begin
        rem  = rem - 7'd10;
        tens = tens + 4'd1;
      end
    end
    return {tens, rem[3:0]};
  endfunction

endpackage

// File: rtl/pong_score_ctrl_if.sv
// Bus between the game-object update stage and the score controller.
//   frame_tick/ball_x/start : update stage -> controller
//   play_en/serve_req/serve_dir/score_p1/score_p2/winner/disp_value :
//                             controller -> update stage and display
// master = update stage side, slave = score controller side.
interface pong_score_ctrl_if #(
  parameter int SCORE_W = 4
);
  logic                 frame_tick;
  logic [11:0]          ball_x;
  logic                 start;
  logic                 play_en;
  logic                 serve_req;
  logic                 serve_dir;
  logic [SCORE_W-1:0]   score_p1;
  logic [SCORE_W-1:0]   score_p2;
  logic [1:0]           winner;
  logic [23:0]          disp_value;

  modport master (
    output frame_tick, ball_x, start,
    input  play_en, serve_req, serve_dir, score_p1, score_p2, winner, disp_value
  );

  modport slave (
    input  frame_tick, ball_x, start,
    output play_en, serve_req, serve_dir, score_p1, score_p2, winner, disp_value
  );
endinterface

// File: rtl/pong_score_ctrl_frame_timer.sv
// Frame counter for the serve delay.
//   clk, rst : clock, async active-high reset
//   i_clr    : synchronous clear (wins over counting)
//   i_en     : counting allowed
//   i_tick   : frame pulse
//   o_tc     : combinational pulse on the tick that brings the count to TERM
module pong_score_ctrl_frame_timer #(
  parameter int TERM = 60
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  input  logic i_tick,
  output logic o_tc
);
  localparam int CNT_W = $clog2(TERM + 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                r_cnt <= '0;
    else if (i_clr)         r_cnt <= '0;
    else if (i_en && i_tick) r_cnt <= r_cnt + 1'b1;
  end

  assign o_tc = i_en && i_tick && (r_cnt == CNT_W'(TERM - 1));
endmodule

// File: rtl/pong_score_ctrl.sv
// Match/score controller. Samples ball X once per frame in PLAY, detects
// goals at either edge, keeps scores, sequences serve delay / play / game
// over, and drives the scoreboard BCD and ball-motion enable.
//   clk, rst : clock, async active-high reset
//   bus      : slave side of pong_score_ctrl_if (see interface header)
module pong_score_ctrl
  import pong_score_ctrl_pkg::*;
#(
  parameter int SCREEN_W     = 640,
  parameter int BALL_W       = 32,
  parameter int WIN_SCORE    = 9,
  parameter int SCORE_W      = 4,
  parameter int SERVE_FRAMES = 60
) (
  input  logic                clk,
  input  logic                rst,
  pong_score_ctrl_if.slave    bus
);
  // A zero-frame delay still needs one tick to launch the serve.
  localparam int                 TERM  = (SERVE_FRAMES == 0) ? 1 : SERVE_FRAMES;
  localparam logic [SCORE_W-1:0] WIN_S = SCORE_W'(WIN_SCORE);

  state_t               r_state, w_nxt_state;
  logic                 r_play_en, w_nxt_play_en;
  logic                 r_serve_req, w_nxt_serve_req;
  logic                 r_serve_dir, w_nxt_serve_dir;
  logic [SCORE_W-1:0]   r_p1, w_nxt_p1;
  logic [SCORE_W-1:0]   r_p2, w_nxt_p2;
  logic [1:0]           r_winner, w_nxt_winner;
  logic                 w_clr, w_tc;
  logic                 w_left, w_right;
  logic [12:0]          w_right_edge;

  pong_score_ctrl_frame_timer #(.TERM(TERM)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_clr),
    .i_en   (r_state == ST_SERVE_WAIT),
    .i_tick (bus.frame_tick),
    .o_tc   (w_tc)
  );

  // 13-bit sum so ball_x near 4095 cannot wrap below the goal line.
  assign w_right_edge = {1'b0, bus.ball_x} + 13'(BALL_W);
  assign w_left       = (bus.ball_x == '0);
  assign w_right      = (w_right_edge >= 13'(SCREEN_W));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_play_en   <= 1'b0;
      r_serve_req <= 1'b0;
      r_serve_dir <= 1'b1;
      r_p1        <= '0;
      r_p2        <= '0;
      r_winner    <= WIN_NONE;
    end else begin
      r_state     <= w_nxt_state;
      r_play_en   <= w_nxt_play_en;
      r_serve_req <= w_nxt_serve_req;
      r_serve_dir <= w_nxt_serve_dir;
      r_p1        <= w_nxt_p1;
      r_p2        <= w_nxt_p2;
      r_winner    <= w_nxt_winner;
    end
  end

  always_comb begin
    w_nxt_state     = r_state;
    w_nxt_play_en   = r_play_en;
    w_nxt_serve_req = 1'b0;
    w_nxt_serve_dir = r_serve_dir;
    w_nxt_p1        = r_p1;
    w_nxt_p2        = r_p2;
    w_nxt_winner    = r_winner;
    w_clr           = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_nxt_state = ST_SERVE_WAIT;
          w_clr       = 1'b1;
        end
      end
      ST_SERVE_WAIT: begin
        if (w_tc) begin
          w_nxt_serve_req = 1'b1;
          w_nxt_play_en   = 1'b1;
          w_nxt_state     = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (bus.frame_tick) begin
          // Left edge checked first; serve goes toward whoever conceded.
          if (w_left) begin
            w_nxt_p2        = r_p2 + 1'b1;
            w_nxt_serve_dir = 1'b0;
            w_nxt_play_en   = 1'b0;
            w_nxt_state     = ST_POINT;
          end else if (w_right) begin
            w_nxt_p1        = r_p1 + 1'b1;
            w_nxt_serve_dir = 1'b1;
            w_nxt_play_en   = 1'b0;
            w_nxt_state     = ST_POINT;
          end
        end
      end
      ST_POINT: begin
        if (r_p1 == WIN_S) begin
          w_nxt_winner = WIN_P1;
          w_nxt_state  = ST_GAME_OVER;
        end else if (r_p2 == WIN_S) begin
          w_nxt_winner = WIN_P2;
          w_nxt_state  = ST_GAME_OVER;
        end else begin
          w_nxt_state = ST_SERVE_WAIT;
          w_clr       = 1'b1;
        end
      end
      ST_GAME_OVER: begin
        w_nxt_play_en = 1'b0;
        if (bus.start) begin
          w_nxt_p1        = '0;
          w_nxt_p2        = '0;
          w_nxt_winner    = WIN_NONE;
          w_nxt_serve_dir = 1'b1;
          w_nxt_state     = ST_SERVE_WAIT;
          w_clr           = 1'b1;
        end
      end
      default: w_nxt_state = ST_IDLE;
    endcase
  end

  assign bus.play_en    = r_play_en;
  assign bus.serve_req  = r_serve_req;
  assign bus.serve_dir  = r_serve_dir;
  assign bus.score_p1   = r_p1;
  assign bus.score_p2   = r_p2;
  assign bus.winner     = r_winner;
  assign bus.disp_value = {bin2bcd(7'(r_p1)), BCD_BLANK, BCD_BLANK, bin2bcd(7'(r_p2))};
endmodule

// File: tb/tb_pong_score_ctrl.sv
module tb_pong_score_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  pong_score_ctrl_if #(.SCORE_W(4)) bus ();

  pong_score_ctrl #(
    .SCREEN_W(640), .BALL_W(32), .WIN_SCORE(9), .SCORE_W(4), .SERVE_FRAMES(60)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] bx;
    logic        goal;
    logic [3:0]  p1;
    logic [3:0]  p2;
    logic        dir;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle frame pulse; returns just after the edge that samples it.
  task automatic tick(input logic [11:0] x);
    bus.frame_tick = 1'b1;
    bus.ball_x     = x;
    step();
    bus.frame_tick = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  // Countdown from SERVE_WAIT: no serve on ticks 1..59, serve on tick 60.
  task automatic do_serve(input logic exp_dir);
    int early = 0;
    for (int i = 1; i <= 60; i++) begin
      tick(12'd300);
      if (i < 60) begin
        if (bus.serve_req !== 1'b0 || bus.play_en !== 1'b0) early++;
        step();
      end
    end
    chk("serve_early", 32'(early), 32'd0);
    chk("serve_req", 32'(bus.serve_req), 32'd1);
    chk("serve_play_en", 32'(bus.play_en), 32'd1);
    chk("serve_dir", 32'(bus.serve_dir), 32'(exp_dir));
    step();
    chk("serve_req_one_cycle", 32'(bus.serve_req), 32'd0);
  endtask

  initial begin
    tbl[0] = '{bx: 12'd300,  goal: 1'b0, p1: 4'd0, p2: 4'd0, dir: 1'b1};
    tbl[1] = '{bx: 12'd607,  goal: 1'b0, p1: 4'd0, p2: 4'd0, dir: 1'b1};
    tbl[2] = '{bx: 12'd0,    goal: 1'b1, p1: 4'd0, p2: 4'd1, dir: 1'b0};
    tbl[3] = '{bx: 12'd608,  goal: 1'b1, p1: 4'd1, p2: 4'd1, dir: 1'b1};
    tbl[4] = '{bx: 12'd4095, goal: 1'b1, p1: 4'd2, p2: 4'd1, dir: 1'b1};
    tbl[5] = '{bx: 12'd1,    goal: 1'b0, p1: 4'd2, p2: 4'd1, dir: 1'b1};
    tbl[6] = '{bx: 12'd608,  goal: 1'b1, p1: 4'd3, p2: 4'd1, dir: 1'b1};

    bus.frame_tick = 1'b0;
    bus.ball_x     = 12'd0;
    bus.start      = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();

    chk("rst_play_en", 32'(bus.play_en), 32'd0);
    chk("rst_serve_req", 32'(bus.serve_req), 32'd0);
    chk("rst_serve_dir", 32'(bus.serve_dir), 32'd1);
    chk("rst_p1", 32'(bus.score_p1), 32'd0);
    chk("rst_p2", 32'(bus.score_p2), 32'd0);
    chk("rst_winner", 32'(bus.winner), 32'd0);
    chk("rst_disp", 32'(bus.disp_value), 32'h00FF00);

    // Ticks in IDLE are ignored, even ball_x=0.
    repeat (3) tick(12'd0);
    chk("idle_p2", 32'(bus.score_p2), 32'd0);
    chk("idle_play_en", 32'(bus.play_en), 32'd0);

    // start with a coincident tick: that tick must not count.
    bus.start = 1'b1;
    bus.frame_tick = 1'b1;
    bus.ball_x = 12'd300;
    step();
    bus.start = 1'b0;
    bus.frame_tick = 1'b0;
    step();
    do_serve(1'b1);

    // start ignored in PLAY.
    pulse_start();
    chk("play_start_ign_en", 32'(bus.play_en), 32'd1);
    chk("play_start_ign_req", 32'(bus.serve_req), 32'd0);

    for (int r = 0; r < 7; r++) begin
      tick(tbl[r].bx);
      chk($sformatf("tbl%0d_p1", r), 32'(bus.score_p1), 32'(tbl[r].p1));
      chk($sformatf("tbl%0d_p2", r), 32'(bus.score_p2), 32'(tbl[r].p2));
      chk($sformatf("tbl%0d_dir", r), 32'(bus.serve_dir), 32'(tbl[r].dir));
      chk($sformatf("tbl%0d_play_en", r), 32'(bus.play_en), 32'(!tbl[r].goal));
      if (tbl[r].goal) begin
        step();
        do_serve(tbl[r].dir);
      end
    end
    chk("disp_3_1", 32'(bus.disp_value), 32'h03FF01);

    // Run p1 up to the winning score.
    for (int k = 4; k <= 9; k++) begin
      tick(12'd608);
      chk($sformatf("win_run_p1_%0d", k), 32'(bus.score_p1), 32'(k));
      step();
      if (k < 9) do_serve(1'b1);
    end
    chk("go_winner", 32'(bus.winner), 32'h1);
    chk("go_play_en", 32'(bus.play_en), 32'd0);
    chk("go_disp", 32'(bus.disp_value), 32'h09FF01);

    // Ticks in GAME_OVER change nothing.
    for (int i = 0; i < 3; i++) begin
      tick(12'd0);
      step();
    end
    chk("go_tick_p2", 32'(bus.score_p2), 32'd1);
    chk("go_tick_p1", 32'(bus.score_p1), 32'd9);
    chk("go_tick_winner", 32'(bus.winner), 32'h1);

    pulse_start();
    chk("restart_p1", 32'(bus.score_p1), 32'd0);
    chk("restart_p2", 32'(bus.score_p2), 32'd0);
    chk("restart_winner", 32'(bus.winner), 32'd0);
    chk("restart_dir", 32'(bus.serve_dir), 32'd1);
    chk("restart_disp", 32'(bus.disp_value), 32'h00FF00);
    do_serve(1'b1);

    // Concede on the left, then reset partway through the countdown.
    tick(12'd0);
    chk("pre_rst_p2", 32'(bus.score_p2), 32'd1);
    chk("pre_rst_dir", 32'(bus.serve_dir), 32'd0);
    step();
    for (int i = 0; i < 30; i++) begin
      tick(12'd300);
      step();
    end
    rst = 1'b1;
    #2;
    chk("async_rst_p2", 32'(bus.score_p2), 32'd0);
    chk("async_rst_dir", 32'(bus.serve_dir), 32'd1);
    chk("async_rst_req", 32'(bus.serve_req), 32'd0);
    chk("async_rst_play", 32'(bus.play_en), 32'd0);
    step();
    rst = 1'b0;
    step();

    // Back in IDLE: ticks alone never produce a serve.
    begin
      int seen = 0;
      for (int i = 0; i < 62; i++) begin
        tick(12'd300);
        if (bus.serve_req !== 1'b0 || bus.play_en !== 1'b0) seen++;
        step();
      end
      chk("post_rst_no_serve", 32'(seen), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
